// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM receive-side demultiplexer.
//   state_e       : framing FSM encoding (HUNT = searching, LOCK = aligned)
//   DEF_NUM_CH    : default channels per frame
//   DEF_DATA_W    : default bits per channel sample
// -----------------------------------------------------------------------------
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_DATA_W = 1;

endpackage

// File: rtl/tdm_demux_sel_decoder.sv
// -----------------------------------------------------------------------------
// sel_decoder
// Binary channel select to one-hot decoder. The output is all zeros when the
// enable is low, so it can be registered directly as the strobe next-state.
//   en_i      in   1             decode enable (a slot write happens)
//   sel_i     in   SEL_W         binary slot index
//   onehot_o  out  2**SEL_W      one-hot slot, zero when en_i=0
// -----------------------------------------------------------------------------
module sel_decoder #(
  parameter int SEL_W = 3
) (
  input  logic                    en_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [(1<<SEL_W)-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// Time-division demultiplexer: takes a serial stream of channel samples framed
// by frame_sync, steers each sample to its slot via a select counter, presents
// every steered sample for one cycle and the complete frame as a parallel word.
//
// Input qualification: din and frame_sync are only meaningful in a cycle with
// din_valid=1 (a "beat"). There is no back-pressure; every beat is consumed in
// the cycle it is presented. Cycles without a beat hold all internal state.
//
//   clk          in   1              rising-edge clock
//   reset        in   1              synchronous, active-high
//   din_valid    in   1              beat qualifier
//   din          in   DATA_W         serial sample
//   frame_sync   in   1              beat carries channel 0
//   ch_strobe    out  NUM_CH         one-hot slot written by the last beat
//   ch_data      out  DATA_W         last accepted sample
//   frame_data   out  NUM_CH*DATA_W  last complete frame, channel k at [k*DATA_W +: DATA_W]
//   frame_valid  out  1              one-cycle pulse when frame_data updates
//   locked       out  1              framing FSM is in LOCK (FSM state observation)
//   sync_err     out  1              one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     din_valid,
  input  logic [DATA_W-1:0]        din,
  input  logic                     frame_sync,
  output logic [NUM_CH-1:0]        ch_strobe,
  output logic [DATA_W-1:0]        ch_data,
  output logic [NUM_CH*DATA_W-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     locked,
  output logic                     sync_err
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);

  // FSM and select counter
  state_e              state_q, state_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;

  // Beat decode results
  logic                wr_en;
  logic [SEL_W-1:0]    wr_slot;
  logic                frame_done;
  logic                sync_err_d;
  logic [NUM_CH-1:0]   ch_strobe_d;

  // Slots 0..NUM_CH-2 wait here; the last slot goes straight into frame_data.
  logic [NUM_CH-2:0][DATA_W-1:0] shadow_q;

  // Output registers
  logic [NUM_CH-1:0]        ch_strobe_q;
  logic [DATA_W-1:0]        ch_data_q;
  logic [NUM_CH*DATA_W-1:0] frame_data_q;
  logic                     frame_valid_q;
  logic                     sync_err_q;

  // ---------------------------------------------------------------------------
  // Next-state / beat decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
    wr_slot    = '0;
    sync_err_d = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          // Unsynced beats are silently dropped while searching.
          if (frame_sync) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            cnt_d   = SEL_W'(1);
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (frame_sync) begin
            // Sync always restarts the frame at slot 0; it is only an error
            // when it cuts a frame short (cnt has not wrapped back to 0).
            sync_err_d = (cnt_q != '0);
            wr_en      = 1'b1;
            wr_slot    = '0;
            cnt_d      = SEL_W'(1);
          end else if (cnt_q == '0) begin
            // Expected a sync at the frame boundary: lose lock.
            sync_err_d = 1'b1;
            cnt_d      = '0;
            state_d    = HUNT;
          end else begin
            wr_en   = 1'b1;
            wr_slot = cnt_q;
            cnt_d   = cnt_q + 1'b1;   // wraps to 0 after the last slot
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A sync beat always writes slot 0, so a sync on the last slot never
  // completes a frame.
  assign frame_done = wr_en && (wr_slot == LAST_SLOT);

  sel_decoder #(
    .SEL_W (SEL_W)
  ) u_sel_decoder (
    .en_i     (wr_en),
    .sel_i    (wr_slot),
    .onehot_o (ch_strobe_d)
  );

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      cnt_q         <= '0;
      shadow_q      <= '0;
      ch_strobe_q   <= '0;
      ch_data_q     <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ch_strobe_q   <= ch_strobe_d;
      frame_valid_q <= frame_done;
      sync_err_q    <= sync_err_d;
      if (wr_en) begin
        ch_data_q <= din;
      end
      for (int k = 0; k < NUM_CH - 1; k++) begin
        if (wr_en && (wr_slot == SEL_W'(k))) begin
          shadow_q[k] <= din;
        end
      end
      if (frame_done) begin
        frame_data_q <= {din, shadow_q};
      end
    end
  end

  assign ch_strobe   = ch_strobe_q;
  assign ch_data     = ch_data_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCK);

endmodule
